ch_readout_serializer: RTL and testbench

- Per-channel transmit side of the POCI readout path: shifts the channel's timestamp/status registers out serially, MSB first, on `poci_ch`.
- One instance per channel (8 total). Each output feeds one bit of the POCI output multiplexer's `poci_ch[7:0]` bus.
- Responds only to register addresses inside its own channel window.
- Supports single-word reads and, optionally, auto-incrementing burst reads across the channel's registers.

---
 rtl/ch_readout_serializer_if.sv | 31 +++
 rtl/ch_readout_serializer.sv | 117 +++++++++++
 tb/tb_ch_readout_serializer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ch_readout_serializer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// ch_readout_serializer_if : read-address / serial-out bundle of one POCI channel
// Revision 1.0
// ------------------------------------------------------------------
interface ch_readout_serializer_if #(
  parameter int NUM_REGS_PER_CH = 7,
  parameter int REG_WIDTH       = 8
);
  localparam int IDX_W = (NUM_REGS_PER_CH > 1) ? $clog2(NUM_REGS_PER_CH) : 1;

  logic                                 cs;
  logic [6:0]                           addr;
  logic                                 addr_valid;
  logic [NUM_REGS_PER_CH*REG_WIDTH-1:0] ch_regs;
  logic                                 poci_ch;
  logic                                 busy;
  logic                                 rd_done;
  logic [IDX_W-1:0]                     reg_idx;

  modport master (
    output cs, addr, addr_valid, ch_regs,
    input  poci_ch, busy, rd_done, reg_idx
  );

  modport slave (
    input  cs, addr, addr_valid, ch_regs,
    output poci_ch, busy, rd_done, reg_idx
  );
endinterface
`default_nettype wire

// File: rtl/ch_readout_serializer.sv
`default_nettype none
// ------------------------------------------------------------------
// ch_readout_serializer : MSB-first serializer for one channel's registers; define READOUT_AUTO_INC_EN for burst reads
// Revision 1.0
// ------------------------------------------------------------------
module ch_readout_serializer #(
  parameter int CH_INDEX          = 0,
  parameter int CH_REG_START_ADDR = 12,
  parameter int NUM_REGS_PER_CH   = 7,
  parameter int REG_WIDTH         = 8
) (
  input  logic                     spi_clk,
  input  logic                     rstn,
  ch_readout_serializer_if.slave   bus
);
  localparam int          IDX_W     = (NUM_REGS_PER_CH > 1) ? $clog2(NUM_REGS_PER_CH) : 1;
  localparam int          CNT_W     = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam int          NUM_SLOTS = 1 << IDX_W;
  localparam int unsigned c_CH_BASE = CH_REG_START_ADDR + CH_INDEX * NUM_REGS_PER_CH;
  localparam int unsigned c_CH_END  = c_CH_BASE + NUM_REGS_PER_CH;

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_SHIFT = 1'b1;

  logic [0:0]           r_state;
  logic [REG_WIDTH-1:0] r_sr;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_poci;
  logic                 r_done;

  logic [31:0]          w_addr_ext;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_go_load;
  logic [IDX_W-1:0]     w_load_idx;
  logic [REG_WIDTH-1:0] w_load_word;
  logic [REG_WIDTH-1:0] w_words [NUM_SLOTS];

  assign w_addr_ext = {25'd0, bus.addr};
  assign w_hit      = bus.addr_valid && (w_addr_ext >= c_CH_BASE) && (w_addr_ext < c_CH_END);
  assign w_hit_idx  = IDX_W'(w_addr_ext - 32'(c_CH_BASE));

  // Pad the word table to a power of two so any index value selects a defined word.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_words
    if (g < NUM_REGS_PER_CH) begin : g_real
      assign w_words[g] = bus.ch_regs[g*REG_WIDTH +: REG_WIDTH];
    end else begin : g_pad
      assign w_words[g] = '0;
    end
  end

`ifdef READOUT_AUTO_INC_EN
  logic [IDX_W-1:0] w_next_idx;
  logic             w_last_reg;
  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_last_reg = (r_idx == IDX_W'(NUM_REGS_PER_CH - 1));
`endif

  // A load comes from an address hit, or from the burst step once the last bit is out.
  always_comb begin
    w_go_load  = 1'b0;
    w_load_idx = w_hit_idx;
    if (w_hit) begin
      w_go_load = 1'b1;
`ifdef READOUT_AUTO_INC_EN
    end else if (!bus.addr_valid && (r_state == c_SHIFT) && (r_cnt == '0) && !w_last_reg) begin
      w_go_load  = 1'b1;
      w_load_idx = w_next_idx;
`endif
    end
  end

  assign w_load_word = w_words[w_load_idx];

  always_ff @(posedge spi_clk) begin
    if (!rstn) begin
      r_state <= c_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_poci  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!bus.cs) begin
      r_state <= c_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_poci  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_go_load) begin
      // MSB goes straight to the output; the shift register keeps the remaining bits.
      r_state <= c_SHIFT;
      r_idx   <= w_load_idx;
      r_sr    <= w_load_word << 1;
      r_poci  <= w_load_word[REG_WIDTH-1];
      r_cnt   <= CNT_W'(REG_WIDTH - 1);
      r_done  <= (REG_WIDTH == 1);
    end else if ((r_state == c_SHIFT) && !bus.addr_valid && (r_cnt != '0)) begin
      r_sr    <= r_sr << 1;
      r_poci  <= r_sr[REG_WIDTH-1];
      r_cnt   <= r_cnt - CNT_W'(1);
      r_done  <= (r_cnt == CNT_W'(1));
    end else begin
      r_state <= c_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_poci  <= 1'b0;
      r_done  <= 1'b0;
    end
  end

  assign bus.poci_ch = r_poci;
  assign bus.busy    = (r_state == c_SHIFT);
  assign bus.rd_done = r_done;
  assign bus.reg_idx = r_idx;
endmodule
`default_nettype wire

// File: tb/tb_ch_readout_serializer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ch_readout_serializer : scoreboard bench for ch_readout_serializer (CH_INDEX=2, window 26..32)
// Revision 1.0
// ------------------------------------------------------------------
module tb_ch_readout_serializer;
  localparam int NREG = 7;
  localparam int W    = 8;

  typedef struct packed {
    logic       poci;
    logic       busy;
    logic       done;
    logic       chk_idx;
    logic [2:0] idx;
  } exp_t;

  logic       spi_clk = 1'b0;
  logic       rstn    = 1'b0;
  int         checks  = 0;
  int         errors  = 0;
  exp_t       exp_q[$];
  string      tag_q[$];
  logic [7:0] regs_v [NREG];

  ch_readout_serializer_if #(.NUM_REGS_PER_CH(NREG), .REG_WIDTH(W)) bus ();

  ch_readout_serializer #(
    .CH_INDEX          (2),
    .CH_REG_START_ADDR (12),
    .NUM_REGS_PER_CH   (NREG),
    .REG_WIDTH         (W)
  ) dut (
    .spi_clk (spi_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  always #5 spi_clk = ~spi_clk;

  always_comb begin
    bus.ch_regs = '0;
    for (int k = 0; k < NREG; k++) bus.ch_regs[k*W +: W] = regs_v[k];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One expectation per cycle: pushed with the stimulus, popped after the edge that produces it.
  always @(posedge spi_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".poci"}, 32'(bus.poci_ch), 32'(e.poci));
      check({t, ".busy"}, 32'(bus.busy),    32'(e.busy));
      check({t, ".done"}, 32'(bus.rd_done), 32'(e.done));
      if (e.chk_idx) check({t, ".idx"}, 32'(bus.reg_idx), 32'(e.idx));
    end
  end

  function automatic exp_t mk(logic p, logic b, logic d, logic c, logic [2:0] i);
    return {p, b, d, c, i};
  endfunction

  task automatic drive(input logic rv, input logic cv, input logic av, input logic [6:0] a,
                       input exp_t e, input string t);
    @(negedge spi_clk);
    rstn           = rv;
    bus.cs         = cv;
    bus.addr_valid = av;
    bus.addr       = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic idle_cyc(input logic cv, input logic av, input logic [6:0] a, input string t);
    drive(1'b1, cv, av, a, mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0), t);
  endtask

  task automatic word_bits(input logic [7:0] w, input int idx, input int from_b, input int to_b,
                           input logic first_av, input logic [6:0] a, input string t);
    for (int b = from_b; b >= to_b; b--)
      drive(1'b1, 1'b1, first_av && (b == from_b), a, mk(w[b], 1'b1, (b == 0), 1'b1, 3'(idx)), t);
  endtask

  task automatic tail(input int idx, input string t);
`ifdef READOUT_AUTO_INC_EN
    for (int k = idx + 1; k < NREG; k++) word_bits(regs_v[k], k, 7, 0, 1'b0, 7'd0, t);
`endif
    idle_cyc(1'b1, 1'b0, 7'd0, t);
  endtask

  task automatic read_burst(input logic [6:0] a, input int idx, input string t);
    word_bits(regs_v[idx], idx, 7, 0, 1'b1, a, t);
    tail(idx, t);
  endtask

  initial begin
    regs_v         = '{8'h96, 8'h11, 8'hA5, 8'h22, 8'hC3, 8'h81, 8'h3C};
    bus.cs         = 1'b0;
    bus.addr_valid = 1'b0;
    bus.addr       = 7'd0;

    drive(1'b0, 1'b1, 1'b1, 7'd28, mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0), "reset");
    drive(1'b0, 1'b1, 1'b1, 7'd28, mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0), "reset");
    idle_cyc(1'b1, 1'b0, 7'd0, "post_reset");

    read_burst(7'd28, 2, "single_a5");

    idle_cyc(1'b1, 1'b1, 7'd25,  "below_win");
    idle_cyc(1'b1, 1'b1, 7'd33,  "above_win");
    idle_cyc(1'b1, 1'b1, 7'd0,   "addr0");
    idle_cyc(1'b1, 1'b1, 7'd127, "addr127");

    read_burst(7'd26, 0, "low_edge");
    read_burst(7'd32, 6, "high_edge");
    read_burst(7'd31, 5, "burst_81_3c");

    word_bits(8'hA5, 2, 7, 5, 1'b1, 7'd28, "cs_drop");
    idle_cyc(1'b0, 1'b0, 7'd0,  "cs_low");
    idle_cyc(1'b0, 1'b1, 7'd28, "cs_low_av");
    idle_cyc(1'b1, 1'b0, 7'd0,  "cs_back");
    read_burst(7'd28, 2, "after_cs");

    word_bits(8'hA5, 2, 7, 4, 1'b1, 7'd28, "readdr_old");
    read_burst(7'd30, 4, "readdr_new");

    word_bits(8'hA5, 2, 7, 6, 1'b1, 7'd28, "abort_old");
    idle_cyc(1'b1, 1'b1, 7'd40, "abort");
    idle_cyc(1'b1, 1'b0, 7'd0,  "abort_idle");

    word_bits(8'hC3, 4, 7, 5, 1'b1, 7'd30, "rst_mid");
    drive(1'b0, 1'b1, 1'b0, 7'd0, mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0), "rst_mid_out");
    idle_cyc(1'b1, 1'b0, 7'd0, "rst_release");

    // Register 2 changes right after the load edge; the loaded word must stay 8'hA5.
    word_bits(8'hA5, 2, 7, 7, 1'b1, 7'd28, "snap");
    @(posedge spi_clk);
    #2 regs_v[2] = 8'hFF;
    word_bits(8'hA5, 2, 6, 0, 1'b0, 7'd0, "snap");
    regs_v[2] = 8'hA5;
    tail(2, "snap");

    @(negedge spi_clk);
    @(negedge spi_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
